sine_dds_multi: RTL and testbench

SINE_DDS_MULTI -- requirements
Module: sine_dds_multi

---
 rtl/sine_dds_multi.sv | 155 +++++++++++++++
 tb/tb_sine_dds_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sine_dds_multi.sv
// Multi-channel DDS: per-channel phase accumulators on a shared sample tick,
// feeding a two-stage sine/square/saw/off waveform and amplitude pipeline.
module sine_dds_multi #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 16,
    parameter int LUT_AW   = 6,
    parameter int OUT_W    = 8,
    parameter int DIV      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic                      wr_en,
    input  logic [5:0]                wr_addr,
    input  logic [PHASE_W-1:0]        wr_data,
    output logic [CHANNELS*OUT_W-1:0] dout,
    output logic                      sample_valid
);

    localparam int N       = 1 << LUT_AW;
    localparam int CNT_W   = $clog2(DIV);
    localparam int AMP_MAX = (1 << (OUT_W - 1)) - 1;

    localparam logic [OUT_W-1:0]        MID    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] FULL_S = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_OFF    = 2'd3
    } mode_t;

    // Elaboration-time quarter-wave magnitude, sampled at bin centres.
    function automatic int mag_calc(input int i);
        real x, term, sum;
        x    = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(N);
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / (real'(2 * k) * real'(2 * k + 1));
            sum  = sum + term;
        end
        return $rtoi(real'(AMP_MAX) * sum + 0.5);
    endfunction

    logic [OUT_W-2:0] mag_rom [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        localparam int MAG = mag_calc(gi);
        assign mag_rom[gi] = (OUT_W-1)'(MAG);
    end

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             valid1;
    logic [3:0]       wr_ch;
    logic [1:0]       wr_sel;

    assign tick   = ena && (cnt == CNT_W'(DIV - 1));
    assign wr_ch  = wr_addr[5:2];
    assign wr_sel = wr_addr[1:0];

    // NOTE: every flop is written with <= so all blocks see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            valid1       <= 1'b0;
            sample_valid <= 1'b0;
        end else if (ena) begin
            cnt          <= tick ? '0 : cnt + CNT_W'(1);
            valid1       <= tick;
            sample_valid <= valid1;
        end else begin
            sample_valid <= 1'b0;
        end
    end

    for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_ch
        logic [PHASE_W-1:0]        acc;
        logic [PHASE_W-1:0]        ftw;
        logic [7:0]                amp;
        mode_t                     mode;
        logic                      ch_wr;
        logic [LUT_AW-1:0]         idx;
        logic [OUT_W-2:0]          mag;
        logic [OUT_W-1:0]          saw;
        logic signed [OUT_W-1:0]   wave;
        logic signed [OUT_W-1:0]   s1;
        logic [7:0]                amp1;
        logic signed [OUT_W+7:0]   prod;
        logic [OUT_W-1:0]          y;
        logic [OUT_W-1:0]          dout_q;

        assign ch_wr = wr_en && (wr_ch == 4'(gc));

        // Odd quadrants read the table backwards: N-1-idx is ~idx.
        assign idx = acc[PHASE_W-3 -: LUT_AW];
        assign mag = acc[PHASE_W-2] ? mag_rom[~idx] : mag_rom[idx];
        assign saw = acc[PHASE_W-1 -: OUT_W] - MID;

        // NOTE: default first in every branch path so no latch is inferred.
        always_comb begin
            wave = '0;
            case (mode)
                MODE_SINE:   wave = acc[PHASE_W-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
                MODE_SQUARE: wave = acc[PHASE_W-1] ? -FULL_S : FULL_S;
                MODE_SAW:    wave = $signed(saw);
                default:     wave = '0;
            endcase
        end

        // |s*amp| < 2^(OUT_W+7), so the product and floor shift cannot overflow.
        assign prod = s1 * $signed({1'b0, amp1});
        assign y    = OUT_W'(prod >>> 8);

        // NOTE: the per-channel register file is tiny, so it is reset like any flop.
        always_ff @(posedge clk) begin
            if (rst) begin
                acc    <= '0;
                ftw    <= '0;
                amp    <= '0;
                mode   <= MODE_SINE;
                s1     <= '0;
                amp1   <= '0;
                dout_q <= MID;
            end else begin
                if (ch_wr) begin
                    case (wr_sel)
                        2'd0:    ftw  <= wr_data;
                        2'd1:    amp  <= wr_data[7:0];
                        2'd2:    mode <= mode_t'(wr_data[1:0]);
                        default: ;
                    endcase
                end
                // A phase load beats the tick; the pipeline still samples the old phase.
                if (ch_wr && wr_sel == 2'd3) begin
                    acc <= wr_data;
                end else if (tick) begin
                    acc <= acc + ftw;
                end
                if (tick) begin
                    s1   <= wave;
                    amp1 <= amp;
                end
                if (ena && valid1) begin
                    dout_q <= y + MID;
                end
            end
        end

        assign dout[gc*OUT_W +: OUT_W] = dout_q;
    end

endmodule

// File: tb/tb_sine_dds_multi.sv
// Scoreboard bench for sine_dds_multi: expected samples are queued as each
// scenario is driven and popped on every sample_valid strobe.
module tb_sine_dds_multi;

    localparam int CHANNELS = 2;
    localparam int PHASE_W  = 16;
    localparam int OUT_W    = 8;
    localparam int DIV      = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      ena = 1'b0;
    logic                      wr_en = 1'b0;
    logic [5:0]                wr_addr = '0;
    logic [PHASE_W-1:0]        wr_data = '0;
    logic [CHANNELS*OUT_W-1:0] dout;
    logic                      sample_valid;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q [$];
    logic        stalled = 1'b0;
    logic [15:0] last_dout = '0;
    logic        prev_valid = 1'b0;
    logic [7:0]  sine_seq [4] = '{8'd129, 8'd254, 8'd126, 8'd1};

    sine_dds_multi #(
        .CHANNELS (CHANNELS),
        .PHASE_W  (PHASE_W),
        .LUT_AW   (6),
        .OUT_W    (OUT_W),
        .DIV      (DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .dout         (dout),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input int ch, input int sel, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = {4'(ch), 2'(sel)};
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ena   = 1'b0;
        wr_en = 1'b0;
        step(2);
        rst   = 1'b0;
    endtask

    task automatic wait_level(input int lvl, input string tag);
        int n;
        n = 0;
        while (exp_q.size() > lvl && n < 300) begin
            step(1);
            n++;
        end
        check(tag, exp_q.size(), lvl);
    endtask

    always @(negedge clk) begin
        logic [15:0] exp;
        if (sample_valid) begin
            check("valid_width", prev_valid, 0);
            if (stalled) check("stall_valid", sample_valid, 0);
            if (exp_q.size() == 0) begin
                check("spurious_valid", sample_valid, 0);
            end else begin
                exp = exp_q.pop_front();
                check("sample", dout, exp);
            end
        end else if (!rst) begin
            check("hold", dout, last_dout);
        end
        last_dout  = dout;
        prev_valid = sample_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values and quiet period with ena low.
        do_reset();
        check("rst_dout", dout, 16'h8080);
        check("rst_valid", sample_valid, 0);
        for (int i = 0; i < 2; i++) begin
            step(1);
            check("post_rst_valid", sample_valid, 0);
        end

        // Ch0 quarter-rate sine; writes to nonexistent channel 5 must not reach ch1.
        do_reset();
        write_reg(0, 0, 16'h4000);
        write_reg(0, 1, 16'h00ff);
        write_reg(0, 2, 16'h0000);
        write_reg(5, 0, 16'h1234);
        write_reg(5, 1, 16'h00ff);
        write_reg(5, 2, 16'h0001);
        write_reg(5, 3, 16'h4000);
        for (int k = 0; k < 8; k++) exp_q.push_back({8'h80, sine_seq[k % 4]});
        ena = 1'b1;
        wait_level(4, "sine_first_half");
        // Stall mid-stream: no strobe, dout frozen, then resume in sequence.
        ena     = 1'b0;
        stalled = 1'b1;
        step(10);
        stalled = 1'b0;
        ena     = 1'b1;
        wait_level(0, "sine_drain");
        ena = 1'b0;

        // Ch1 half-rate square at half amplitude.
        do_reset();
        write_reg(1, 2, 16'h0001);
        write_reg(1, 1, 16'h0080);
        write_reg(1, 0, 16'h8000);
        for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 16'hbf80 : 16'h4080);
        ena = 1'b1;
        wait_level(0, "square_drain");
        ena = 1'b0;

        // Ch0 saw, FTW=0; phase load lands exactly on the second tick.
        do_reset();
        write_reg(0, 2, 16'h0002);
        write_reg(0, 1, 16'h00ff);
        write_reg(0, 3, 16'h4000);
        exp_q.push_back(16'h8040);
        exp_q.push_back(16'h8040);
        exp_q.push_back(16'h8080);
        exp_q.push_back(16'h8080);
        ena = 1'b1;
        step(7);
        write_reg(0, 3, 16'h8000);
        wait_level(0, "saw_drain");
        ena = 1'b0;

        // Reset with a sample in flight, ena high and a write pending.
        do_reset();
        write_reg(0, 0, 16'h4000);
        write_reg(0, 1, 16'h00ff);
        ena = 1'b1;
        step(4);
        rst     = 1'b1;
        wr_en   = 1'b1;
        wr_addr = {4'd0, 2'd1};
        wr_data = 16'h00ff;
        step(2);
        rst   = 1'b0;
        wr_en = 1'b0;
        ena   = 1'b0;
        check("mid_rst_dout", dout, 16'h8080);
        exp_q.push_back(16'h8080);
        exp_q.push_back(16'h8080);
        ena = 1'b1;
        wait_level(0, "post_rst_drain");
        ena = 1'b0;

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
